// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: FSM states,
// opcode/funct values, ALU commands and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU command and flags unsupported codes.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Define MIPS_BNE_EN to decode bne (opcode 000101) as a branch on ~zero.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     cur;
    logic [2:0] fn_op;
    logic       fn_bad;

    mips_alu_decoder u_alu_decoder (
        .funct   (funct),
        .alu_op  (fn_op),
        .illegal (fn_bad)
    );

    assign state = cur;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= S_FETCH;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (cur)
                S_FETCH:  cur <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_RTYPE:     cur <= S_EXEC;
                        OP_BEQ:       cur <= S_BRANCH;
`ifdef MIPS_BNE_EN
                        OP_BNE:       cur <= S_BRANCH;
`endif
                        OP_ADDI:      cur <= S_ADDIEX;
                        OP_J:         cur <= S_JUMP;
                        default: begin
                            cur     <= S_FETCH;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  cur <= S_MEMWB;
                S_EXEC: begin
                    if (fn_bad) begin
                        cur     <= S_FETCH;
                        illegal <= 1'b1;
                    end else begin
                        cur <= S_ALUWB;
                    end
                end
                S_ADDIEX: cur <= S_ADDIWB;
                // Final state of every completed instruction: retire it.
                S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                    cur         <= S_FETCH;
                    instr_count <= instr_count + CNT_ONE;
                end
                default:  cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        pc_en      = 1'b0;
        case (cur)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_en     = 1'b1;
                alu_src_b = SRCB_FOUR;
            end
            S_DECODE: alu_src_b = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = fn_op;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
`ifdef MIPS_BNE_EN
                pc_en     = (opcode == OP_BNE) ? ~zero : zero;
`else
                pc_en     = zero;
`endif
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset holds the FSM in FETCH; its write enables must not reach the datapath.
        if (reset) begin
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_en     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl; expected sequences are hand-derived.
// Build with +define+MIPS_BNE_EN to exercise the bne decode path.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic        pc_en, illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    logic       rw_l   [8];
    logic       mw_l   [8];
    logic       m2r_l  [8];
    logic       rdst_l [8];
    logic       pcen_l [8];
    logic [1:0] src_l  [8];
    logic [2:0] aop_l  [8];
    int         rw_n;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .illegal     (illegal),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; seq holds the expected state of cycle i in nibble i.
    task automatic walk(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int n, input logic [31:0] seq,
                        input bit retire, input logic exp_ill);
        opcode = op;
        funct  = fn;
        zero   = z;
        rw_n   = 0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_st%0d", tag, i), {28'd0, state}, {28'd0, seq[4*i +: 4]});
            if (i == 1) check({tag, "_ill_clr"}, {31'd0, illegal}, 32'd0);
            rw_l[i]   = reg_write;
            mw_l[i]   = mem_write;
            m2r_l[i]  = mem_to_reg;
            rdst_l[i] = reg_dst;
            pcen_l[i] = pc_en;
            src_l[i]  = pc_src;
            aop_l[i]  = alu_op;
            if (reg_write) rw_n++;
            step();
        end
        if (retire) exp_cnt++;
        check({tag, "_end_st"}, {28'd0, state}, 32'd0);
        check({tag, "_cnt"}, instr_count, exp_cnt);
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100000;
        zero   = 1'b0;
        step();
        step();
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_cnt", instr_count, 32'd0);
        check("rst_irw", {31'd0, ir_write}, 32'd0);
        check("rst_pcen", {31'd0, pc_en}, 32'd0);
        check("rst_srcb", {30'd0, alu_src_b}, 32'd1);
        check("rst_aluop", {29'd0, alu_op}, 32'd2);
        check("rst_ill", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_irw", {31'd0, ir_write}, 32'd1);
        check("rel_pcen", {31'd0, pc_en}, 32'd1);

        walk("lw", 6'b100011, 6'd0, 1'b0, 5, 32'h43210, 1'b1, 1'b0);
        check("lw_rw4", {31'd0, rw_l[4]}, 32'd1);
        check("lw_m2r4", {31'd0, m2r_l[4]}, 32'd1);
        check("lw_rdst4", {31'd0, rdst_l[4]}, 32'd0);
        check("lw_rw_n", rw_n, 32'd1);

        walk("sw", 6'b101011, 6'd0, 1'b0, 4, 32'h5210, 1'b1, 1'b0);
        check("sw_mw3", {31'd0, mw_l[3]}, 32'd1);
        check("sw_rw_n", rw_n, 32'd0);

        walk("slt", 6'b000000, 6'b101010, 1'b0, 4, 32'h7610, 1'b1, 1'b0);
        check("slt_op", {29'd0, aop_l[2]}, 32'h7);
        check("slt_rdst", {31'd0, rdst_l[3]}, 32'd1);
        check("slt_rw", {31'd0, rw_l[3]}, 32'd1);

        walk("sub", 6'b000000, 6'b100010, 1'b0, 4, 32'h7610, 1'b1, 1'b0);
        check("sub_op", {29'd0, aop_l[2]}, 32'h6);

        walk("beq_t", 6'b000100, 6'd0, 1'b1, 3, 32'h810, 1'b1, 1'b0);
        check("beq_t_pcen", {31'd0, pcen_l[2]}, 32'd1);
        check("beq_t_src", {30'd0, src_l[2]}, 32'd1);
        check("beq_t_op", {29'd0, aop_l[2]}, 32'h6);

        walk("beq_n", 6'b000100, 6'd0, 1'b0, 3, 32'h810, 1'b1, 1'b0);
        check("beq_n_pcen", {31'd0, pcen_l[2]}, 32'd0);

        walk("addi", 6'b001000, 6'd0, 1'b0, 4, 32'hA910, 1'b1, 1'b0);
        check("addi_rw", {31'd0, rw_l[3]}, 32'd1);
        check("addi_rdst", {31'd0, rdst_l[3]}, 32'd0);

        walk("j", 6'b000010, 6'd0, 1'b0, 3, 32'hB10, 1'b1, 1'b0);
        check("j_pcen", {31'd0, pcen_l[2]}, 32'd1);
        check("j_src", {30'd0, src_l[2]}, 32'd2);

        walk("badop", 6'b111111, 6'd0, 1'b0, 2, 32'h10, 1'b0, 1'b1);
        check("badop_rw_n", rw_n, 32'd0);

        walk("badfn", 6'b000000, 6'b000111, 1'b0, 3, 32'h610, 1'b0, 1'b1);
        check("badfn_rw_n", rw_n, 32'd0);

`ifdef MIPS_BNE_EN
        walk("bne_n", 6'b000101, 6'd0, 1'b0, 3, 32'h810, 1'b1, 1'b0);
        check("bne_n_pcen", {31'd0, pcen_l[2]}, 32'd1);
        walk("bne_t", 6'b000101, 6'd0, 1'b1, 3, 32'h810, 1'b1, 1'b0);
        check("bne_t_pcen", {31'd0, pcen_l[2]}, 32'd0);
`else
        walk("bne", 6'b000101, 6'd0, 1'b0, 2, 32'h10, 1'b0, 1'b1);
`endif

        // Abort an lw in MEMRD with an asynchronous reset between clock edges.
        opcode = 6'b100011;
        step();
        step();
        step();
        check("mid_st", {28'd0, state}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        check("mid_rst_st", {28'd0, state}, 32'd0);
        check("mid_rst_cnt", instr_count, 32'd0);
        check("mid_rst_irw", {31'd0, ir_write}, 32'd0);
        check("mid_rst_pcen", {31'd0, pc_en}, 32'd0);
        check("mid_rst_rw", {31'd0, reg_write}, 32'd0);
        check("mid_rst_mw", {31'd0, mem_write}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rel_irw", {31'd0, ir_write}, 32'd1);
        check("mid_rel_pcen", {31'd0, pc_en}, 32'd1);
        walk("lw2", 6'b100011, 6'd0, 1'b0, 5, 32'h43210, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
